// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 constants, round helper functions and core state encoding (SHA256_SHA224_MODE_EN adds the SHA-224 IV)
package sha256_pkg;
  typedef enum logic [1:0] {IDLE, COMP, FINAL, OUT} state_e;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV256 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
`ifdef SHA256_SHA224_MODE_EN
  localparam logic [255:0] IV224 = 256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;
`endif
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] ch(input logic [31:0] e, f, g);
    return (e & f) ^ (~e & g);
  endfunction
  function automatic logic [31:0] maj(input logic [31:0] a, b, c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction
  function automatic logic [31:0] Sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] Sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
endpackage

// File: rtl/sha256_stream_core_if.sv
// sha256_stream_core_if: block input / digest output stream bundle (mode_224 only with SHA256_SHA224_MODE_EN)
interface sha256_stream_core_if;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;
  logic         digest_valid;
  logic         digest_ready;
  logic [255:0] digest;
  logic         busy;
`ifdef SHA256_SHA224_MODE_EN
  logic         mode_224;
`endif
  modport slave (
`ifdef SHA256_SHA224_MODE_EN
    input mode_224,
`endif
    input blk_valid, blk_data, blk_first, blk_last, digest_ready,
    output blk_ready, digest_valid, digest, busy
  );
  modport master (
`ifdef SHA256_SHA224_MODE_EN
    output mode_224,
`endif
    output blk_valid, blk_data, blk_first, blk_last, digest_ready,
    input blk_ready, digest_valid, digest, busy
  );
endinterface

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 compression round, state packed as {a,b,c,d,e,f,g,h}
module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] i_s,
  input  logic [31:0]  i_k,
  input  logic [31:0]  i_w,
  output logic [255:0] o_s
);
  logic [31:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h, w_t1, w_t2;
  assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = i_s;
  assign w_t1 = w_h + Sigma1(w_e) + ch(w_e, w_f, w_g) + i_k + i_w;
  assign w_t2 = Sigma0(w_a) + maj(w_a, w_b, w_c);
  assign o_s = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};
endmodule

// File: rtl/sha256_stream_core.sv
// sha256_stream_core: multi-block streaming SHA-256 engine (SHA256_SHA224_MODE_EN enables SHA-224 output mode)
module sha256_stream_core
  import sha256_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input logic clk,
  input logic rst,
  sha256_stream_core_if.slave bus
);
  localparam int R = ROUNDS_PER_CYCLE;
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_COMP = COMP;
  localparam logic [1:0] S_FINAL = FINAL;
  localparam logic [1:0] S_OUT = OUT;
  logic [1:0]   r_state;
  logic [5:0]   r_t;
  logic [255:0] r_h, r_work, r_digest;
  logic [31:0]  r_w [16];
  logic         r_last, r_chain_ok, r_digest_valid;
  logic [31:0]  w_x [16+R];
  logic [255:0] w_s [R+1];
  logic [255:0] w_iv, w_src, w_sum, w_dig;
  logic         w_fresh;
`ifdef SHA256_SHA224_MODE_EN
  logic         r_mode;
  assign w_iv  = bus.mode_224 ? IV224 : IV256;
  assign w_dig = r_mode ? {w_sum[255:32], 32'h0} : w_sum;
`else
  assign w_iv  = IV256;
  assign w_dig = w_sum;
`endif
  assign w_fresh = bus.blk_first | !r_chain_ok;
  assign w_src   = w_fresh ? w_iv : r_h;
  assign w_s[0]  = r_work;
  assign bus.blk_ready    = r_state == S_IDLE;
  assign bus.busy         = r_state == S_COMP || r_state == S_FINAL;
  assign bus.digest_valid = r_digest_valid;
  assign bus.digest       = r_digest;
  // Extend the 16-word schedule window by the R words consumed this cycle
  always_comb begin
    for (int i = 0; i < 16; i++) w_x[i] = r_w[i];
    for (int i = 16; i < 16 + R; i++) w_x[i] = sig1(w_x[i-2]) + w_x[i-7] + sig0(w_x[i-15]) + w_x[i-16];
  end
  // Feed-forward addition of the working variables into the chaining value
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 8; i++) w_sum[32*i +: 32] = r_h[32*i +: 32] + r_work[32*i +: 32];
  end
  for (genvar g = 0; g < R; g++) begin : g_round
    sha256_round u_round (.i_s(w_s[g]), .i_k(K[r_t + 6'(g)]), .i_w(r_w[g]), .o_s(w_s[g+1]));
  end
  // Block accept, R rounds per cycle, hash update and digest hand-off
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_t            <= '0;
      r_h            <= IV256;
      r_work         <= '0;
      r_digest       <= '0;
      r_last         <= 1'b0;
      r_chain_ok     <= 1'b0;
      r_digest_valid <= 1'b0;
      for (int i = 0; i < 16; i++) r_w[i] <= '0;
`ifdef SHA256_SHA224_MODE_EN
      r_mode         <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (bus.blk_valid) begin
          r_h     <= w_src;
          r_work  <= w_src;
          r_last  <= bus.blk_last;
          r_t     <= '0;
          r_state <= S_COMP;
          for (int i = 0; i < 16; i++) r_w[i] <= bus.blk_data[511-32*i -: 32];
`ifdef SHA256_SHA224_MODE_EN
          if (w_fresh) r_mode <= bus.mode_224;
`endif
        end
        S_COMP: begin
          r_work <= w_s[R];
          r_t    <= r_t + 6'(R);
          for (int i = 0; i < 16; i++) r_w[i] <= w_x[i+R];
          if (r_t == 6'(64 - R)) r_state <= S_FINAL;
        end
        S_FINAL: begin
          r_h        <= w_sum;
          r_chain_ok <= !r_last;
          if (r_last) begin
            r_digest       <= w_dig;
            r_digest_valid <= 1'b1;
            r_state        <= S_OUT;
          end else r_state <= S_IDLE;
        end
        default: if (bus.digest_ready) begin
          r_digest_valid <= 1'b0;
          r_state        <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_stream_core.sv
// tb_sha256_stream_core: directed vectors against R=1 and R=4 instances of the streaming SHA-256 core
module tb_sha256_stream_core;
  localparam logic [511:0] ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] B1 = 512'h6162636462636465636465666465666765666768666768696768696a68696a6b696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f70718000000000000000;
  localparam logic [511:0] B2 = {480'h0, 32'h000001c0};
  localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  typedef struct {
    bit           s;
    logic         f;
    logic         l;
    logic [511:0] d;
    logic [255:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] valid = '0;
  logic [511:0] data = '0;
  logic first = 1'b0, last = 1'b0, dready = 1'b0;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  sha256_stream_core_if bus1();
  sha256_stream_core_if bus4();
  assign bus1.blk_valid = valid[0];
  assign bus4.blk_valid = valid[1];
  assign bus1.blk_data = data;
  assign bus4.blk_data = data;
  assign bus1.blk_first = first;
  assign bus4.blk_first = first;
  assign bus1.blk_last = last;
  assign bus4.blk_last = last;
  assign bus1.digest_ready = dready;
  assign bus4.digest_ready = dready;
`ifdef SHA256_SHA224_MODE_EN
  logic mode = 1'b0;
  assign bus1.mode_224 = mode;
  assign bus4.mode_224 = mode;
`endif
  sha256_stream_core #(.ROUNDS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  sha256_stream_core #(.ROUNDS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
  function automatic logic rdy(input bit s);
    return s ? bus4.blk_ready : bus1.blk_ready;
  endfunction
  function automatic logic dv(input bit s);
    return s ? bus4.digest_valid : bus1.digest_valid;
  endfunction
  function automatic logic bsy(input bit s);
    return s ? bus4.busy : bus1.busy;
  endfunction
  function automatic logic [255:0] dg(input bit s);
    return s ? bus4.digest : bus1.digest;
  endfunction
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic wait_ready(input bit s);
    int n = 0;
    while (!rdy(s) && n < 300) begin @(posedge clk); #1; n++; end
    chk("ready_wait_bound", 256'(n < 300), 1);
  endtask
  task automatic run_blk(input bit s, input logic f, input logic l, input logic [511:0] d, input logic [255:0] exp);
    int n = 0;
    int lat = s ? 17 : 65;
    data = d; first = f; last = l; valid[s] = 1'b1;
    wait_ready(s);
    @(posedge clk); #1;
    valid = '0;
    data = '0;
    chk("busy_after_accept", bsy(s), 1);
    chk("ready_low_after_accept", rdy(s), 0);
    while (!(l ? dv(s) : rdy(s)) && n < 300) begin @(posedge clk); #1; n++; end
    chk(l ? "digest_latency" : "chain_latency", n, lat);
    if (l) begin
      chk("digest", dg(s), exp);
      dready = 1'b1;
      @(posedge clk); #1;
      dready = 1'b0;
      chk("dv_cleared", dv(s), 0);
      chk("ready_after_handshake", rdy(s), 1);
      chk("digest_kept", dg(s), exp);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_t tbl[8];
    int n;
    int spur;
    tbl[0] = '{0, 1, 1, ABC, D_ABC};
    tbl[1] = '{1, 1, 1, EMPTY, D_EMPTY};
    tbl[2] = '{0, 1, 0, B1, '0};
    tbl[3] = '{0, 0, 1, B2, D_TWO};
    tbl[4] = '{1, 1, 0, B1, '0};
    tbl[5] = '{1, 0, 1, B2, D_TWO};
    tbl[6] = '{0, 0, 1, ABC, D_ABC};
    tbl[7] = '{0, 1, 1, EMPTY, D_EMPTY};
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("reset_ready", rdy(1'(s)), 1);
      chk("reset_dv", dv(1'(s)), 0);
      chk("reset_busy", bsy(1'(s)), 0);
      chk("reset_digest", dg(1'(s)), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) run_blk(tbl[i].s, tbl[i].f, tbl[i].l, tbl[i].d, tbl[i].exp);
    data = ABC; first = 1'b1; last = 1'b1; valid[0] = 1'b1;
    wait_ready(0);
    @(posedge clk); #1;
    data = EMPTY;
    n = 0;
    while (!dv(0) && n < 300) begin @(posedge clk); #1; n++; end
    chk("stall_latency", n, 65);
    for (int i = 0; i < 20; i++) begin
      chk("stall_digest", dg(0), D_ABC);
      chk("stall_dv", dv(0), 1);
      chk("stall_ready", rdy(0), 0);
      @(posedge clk); #1;
    end
    valid = '0;
    dready = 1'b1;
    @(posedge clk); #1;
    dready = 1'b0;
    chk("stall_release_dv", dv(0), 0);
    chk("stall_release_ready", rdy(0), 1);
    run_blk(0, 1, 1, ABC, D_ABC);
    data = B1; first = 1'b1; last = 1'b0; valid[0] = 1'b1;
    wait_ready(0);
    @(posedge clk); #1;
    valid = '0;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_ready", rdy(0), 1);
    chk("abort_busy", bsy(0), 0);
    chk("abort_dv", dv(0), 0);
    chk("abort_digest", dg(0), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    spur = 0;
    for (int i = 0; i < 80; i++) begin
      if (dv(0) || bsy(0)) spur++;
      @(posedge clk); #1;
    end
    chk("no_spurious_after_abort", spur, 0);
    run_blk(0, 1, 1, ABC, D_ABC);
`ifdef SHA256_SHA224_MODE_EN
    mode = 1'b1;
    run_blk(0, 1, 1, ABC, 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000);
    mode = 1'b0;
    run_blk(0, 1, 1, ABC, D_ABC);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
